id_ex_pipe_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 22 ++
 rtl/id_ex_pipe_reg_if.sv | 52 +++++
 rtl/sat_counter16.sv | 24 ++
 rtl/id_ex_pipe_reg.sv | 131 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline definitions: control-bit positions, group widths, FSM states.
package pipe_pkg;

    localparam int WB_W  = 2;
    localparam int MEM_W = 2;
    localparam int EX_W  = 4;

    localparam int REGWRITE_BIT = 1;
    localparam int MEMTOREG_BIT = 0;
    localparam int MEMREAD_BIT  = 1;
    localparam int MEMWRITE_BIT = 0;
    localparam int REGDST_BIT   = 3;
    localparam int ALUOP_MSB    = 2;
    localparam int ALUOP_LSB    = 1;
    localparam int ALUSRC_BIT   = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID -> EX bundle: control groups, operands and register addresses in, registered copies out.
interface id_ex_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    import pipe_pkg::*;

    logic [WB_W-1:0]   wb_i;
    logic [MEM_W-1:0]  mem_i;
    logic [EX_W-1:0]   ex_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] pc_i;
    logic [REG_AW-1:0] rs_addr_i;
    logic [REG_AW-1:0] rt_addr_i;
    logic [REG_AW-1:0] rd_addr_i;

    logic [WB_W-1:0]   wb_o;
    logic [MEM_W-1:0]  mem_o;
    logic [EX_W-1:0]   ex_o;
    logic [DATA_W-1:0] rs_data_o;
    logic [DATA_W-1:0] rt_data_o;
    logic [DATA_W-1:0] imm_o;
    logic [DATA_W-1:0] pc_o;
    logic [REG_AW-1:0] rs_addr_o;
    logic [REG_AW-1:0] rt_addr_o;
    logic [REG_AW-1:0] rd_addr_o;
    logic              valid_o;
    logic [REG_AW-1:0] ld_rt_o;

    modport master (
        output wb_i, mem_i, ex_i,
        output rs_data_i, rt_data_i, imm_i, pc_i,
        output rs_addr_i, rt_addr_i, rd_addr_i,
        input  wb_o, mem_o, ex_o,
        input  rs_data_o, rt_data_o, imm_o, pc_o,
        input  rs_addr_o, rt_addr_o, rd_addr_o,
        input  valid_o, ld_rt_o
    );

    modport slave (
        input  wb_i, mem_i, ex_i,
        input  rs_data_i, rt_data_i, imm_i, pc_i,
        input  rs_addr_i, rt_addr_i, rd_addr_i,
        output wb_o, mem_o, ex_o,
        output rs_data_o, rt_data_o, imm_o, pc_o,
        output rs_addr_o, rt_addr_o, rd_addr_o,
        output valid_o, ld_rt_o
    );

endinterface

// File: rtl/sat_counter16.sv
// 16-bit event counter with synchronous clear that sticks at 16'hFFFF.
module sat_counter16 (
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] r_cnt;
    logic        w_full;

    assign w_full = (r_cnt == 16'hFFFF);

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            r_cnt <= 16'h0000;
        end else if (inc_i && !w_full) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with start gate, stall hold, bubble insert and load-target publish.
// Define ID_EX_PERF_CNT_EN to build the issue/bubble saturating counters.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             hold_i,
    input  logic             bubble_i,
    id_ex_pipe_reg_if.slave  bus,
    output logic [15:0]      issue_cnt_o,
    output logic [15:0]      bubble_cnt_o
);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_cap;
    logic   w_bub;

    logic [WB_W-1:0]   r_wb;
    logic [MEM_W-1:0]  r_mem;
    logic [EX_W-1:0]   r_ex;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc;
    logic [REG_AW-1:0] r_rs_addr;
    logic [REG_AW-1:0] r_rt_addr;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start_i) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The start edge itself only arms the register; capture begins in RUN.
    always_comb begin
        w_cap = 1'b0;
        w_bub = 1'b0;
        unique case (r_state)
            RUN: begin
                w_bub = !hold_i && bubble_i;
                w_cap = !hold_i && !bubble_i;
            end
            default: begin
                w_cap = 1'b0;
                w_bub = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || w_bub) begin
            r_wb      <= '0;
            r_mem     <= '0;
            r_ex      <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_pc      <= '0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_rd_addr <= '0;
            r_valid   <= 1'b0;
        end else if (w_cap) begin
            r_wb      <= bus.wb_i;
            r_mem     <= bus.mem_i;
            r_ex      <= bus.ex_i;
            r_rs_data <= bus.rs_data_i;
            r_rt_data <= bus.rt_data_i;
            r_imm     <= bus.imm_i;
            r_pc      <= bus.pc_i;
            r_rs_addr <= bus.rs_addr_i;
            r_rt_addr <= bus.rt_addr_i;
            r_rd_addr <= bus.rd_addr_i;
            r_valid   <= 1'b1;
        end
    end

    assign bus.wb_o      = r_wb;
    assign bus.mem_o     = r_mem;
    assign bus.ex_o      = r_ex;
    assign bus.rs_data_o = r_rs_data;
    assign bus.rt_data_o = r_rt_data;
    assign bus.imm_o     = r_imm;
    assign bus.pc_o      = r_pc;
    assign bus.rs_addr_o = r_rs_addr;
    assign bus.rt_addr_o = r_rt_addr;
    assign bus.rd_addr_o = r_rd_addr;
    assign bus.valid_o   = r_valid;

    // Hazard unit sees the load target from registered state only.
    assign bus.ld_rt_o = (r_valid && r_mem[MEMREAD_BIT]) ? r_rt_addr : '0;

`ifdef ID_EX_PERF_CNT_EN
    sat_counter16 u_issue_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (w_cap),
        .cnt_o (issue_cnt_o)
    );

    sat_counter16 u_bubble_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (w_bub),
        .cnt_o (bubble_cnt_o)
    );
`else
    assign issue_cnt_o  = 16'h0000;
    assign bubble_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg; counter expectations follow ID_EX_PERF_CNT_EN.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hold;
    logic        bubble;
    logic [15:0] ic;
    logic [15:0] bc;

    id_ex_pipe_reg_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .hold_i       (hold),
        .bubble_i     (bubble),
        .bus          (bus),
        .issue_cnt_o  (ic),
        .bubble_cnt_o (bc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  wb;
        logic [1:0]  mem;
        logic [3:0]  ex;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rsa;
        logic [4:0]  rta;
        logic [4:0]  rda;
        logic        valid;
        logic [4:0]  ldrt;
        logic [15:0] icn;
        logic [15:0] bcn;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    function automatic logic [15:0] ce(input int n);
`ifdef ID_EX_PERF_CNT_EN
        return n[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    function automatic snap_t mk(
        input logic [1:0] wb, input logic [1:0] mem, input logic [3:0] ex,
        input logic [31:0] rs, input logic [31:0] rt,
        input logic [31:0] imm, input logic [31:0] pc,
        input logic [4:0] rsa, input logic [4:0] rta, input logic [4:0] rda,
        input logic valid, input logic [4:0] ldrt, input int icn, input int bcn);
        snap_t s;
        s.wb = wb; s.mem = mem; s.ex = ex;
        s.rs = rs; s.rt = rt; s.imm = imm; s.pc = pc;
        s.rsa = rsa; s.rta = rta; s.rda = rda;
        s.valid = valid; s.ldrt = ldrt;
        s.icn = ce(icn); s.bcn = ce(bcn);
        return s;
    endfunction

    function automatic snap_t zs(input int icn, input int bcn);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0, icn, bcn);
    endfunction

    task automatic drive(
        input logic [1:0] wb, input logic [1:0] mem, input logic [3:0] ex,
        input logic [31:0] rs, input logic [31:0] rt,
        input logic [31:0] imm, input logic [31:0] pc,
        input logic [4:0] rsa, input logic [4:0] rta, input logic [4:0] rda);
        bus.wb_i = wb; bus.mem_i = mem; bus.ex_i = ex;
        bus.rs_data_i = rs; bus.rt_data_i = rt;
        bus.imm_i = imm; bus.pc_i = pc;
        bus.rs_addr_i = rsa; bus.rt_addr_i = rta; bus.rd_addr_i = rda;
    endtask

    // One clock edge; the expected post-edge state goes to the scoreboard.
    task automatic step(input bit chk, input string nm, input snap_t e);
        @(posedge clk);
        #1;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    initial begin
        snap_t e;
        snap_t a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a.wb = bus.wb_o; a.mem = bus.mem_o; a.ex = bus.ex_o;
                a.rs = bus.rs_data_o; a.rt = bus.rt_data_o;
                a.imm = bus.imm_o; a.pc = bus.pc_o;
                a.rsa = bus.rs_addr_o; a.rta = bus.rt_addr_o;
                a.rda = bus.rd_addr_o;
                a.valid = bus.valid_o; a.ldrt = bus.ld_rt_o;
                a.icn = ic; a.bcn = bc;
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s: got valid=%b ldrt=%h ic=%h bc=%h all=%h, expected valid=%b ldrt=%h ic=%h bc=%h all=%h",
                             nm, a.valid, a.ldrt, a.icn, a.bcn, a,
                             e.valid, e.ldrt, e.icn, e.bcn, e);
                end
            end
        end
    end

    snap_t exp_a;
    snap_t exp_d;
    int    n;

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0; bubble = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, "", zs(0, 0));
        step(1, "reset", zs(0, 0));

        rst = 1'b0; start = 1'b1;
        drive(2'b10, 2'b00, 4'b1001, 32'h5, 0, 0, 0, 0, 0, 0);
        step(1, "start_edge", zs(0, 0));

        start = 1'b0;
        step(1, "first_cap",
             mk(2'b10, 0, 4'b1001, 32'h5, 0, 0, 0, 0, 0, 0, 1'b1, 0, 1, 0));

        drive(2'b11, 2'b10, 4'b0011, 32'h11, 32'h22, 32'h4, 32'h100, 3, 8, 0);
        step(1, "load_ldrt",
             mk(2'b11, 2'b10, 4'b0011, 32'h11, 32'h22, 32'h4, 32'h100,
                3, 8, 0, 1'b1, 8, 2, 0));

        bubble = 1'b1;
        step(1, "bubble", zs(2, 1));

        bubble = 1'b0;
        drive(2'b10, 2'b01, 4'b1100, 32'hAAAA, 32'hBBBB, 32'hFFFF_FFF0,
              32'h200, 1, 2, 3);
        exp_a = mk(2'b10, 2'b01, 4'b1100, 32'hAAAA, 32'hBBBB, 32'hFFFF_FFF0,
                   32'h200, 1, 2, 3, 1'b1, 0, 3, 1);
        step(1, "store_cap", exp_a);

        hold = 1'b1; bubble = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(2'b01, 2'b11, 4'hF, 32'hC0DE_0000 + k, 32'h1 + k,
                  32'h2 + k, 32'h3 + k, 5'(k + 7), 5'(k + 9), 5'(k + 11));
            step(1, "hold", exp_a);
        end

        hold = 1'b0; bubble = 1'b0;
        drive(2'b01, 2'b10, 4'b0110, 32'h1234, 32'h5678, 32'h9,
              32'h204, 4, 5, 6);
        step(1, "release",
             mk(2'b01, 2'b10, 4'b0110, 32'h1234, 32'h5678, 32'h9,
                32'h204, 4, 5, 6, 1'b1, 5, 4, 1));

        drive(0, 0, 0, 32'h7, 32'h8, 32'h9, 32'h208, 10, 11, 12);
        step(1, "zero_ctrl",
             mk(0, 0, 0, 32'h7, 32'h8, 32'h9, 32'h208, 10, 11, 12,
                1'b1, 0, 5, 1));

        drive(2'b11, 2'b10, 4'b0011, 32'h40, 32'h44, 32'h8, 32'h20C, 2, 9, 0);
        step(1, "load2",
             mk(2'b11, 2'b10, 4'b0011, 32'h40, 32'h44, 32'h8, 32'h20C,
                2, 9, 0, 1'b1, 9, 6, 1));

        hold = 1'b1; rst = 1'b1;
        step(1, "rst_in_hold", zs(0, 0));

        rst = 1'b0; hold = 1'b0;
        drive(2'b11, 2'b11, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
              32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'h1F, 5'h1F, 5'h1F);
        for (int k = 0; k < 4; k++) begin
            hold = k[0]; bubble = k[1];
            step(1, "idle_ignore", zs(0, 0));
        end

        hold = 1'b0; bubble = 1'b0; start = 1'b1;
        step(1, "restart_edge", zs(0, 0));

        start = 1'b0;
        step(1, "dead_cap",
             mk(2'b11, 2'b11, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'h1F, 5'h1F, 5'h1F,
                1'b1, 5'h1F, 1, 0));

        start = 1'b1; bubble = 1'b1;
        step(1, "start_in_run", zs(1, 1));

        start = 1'b0; bubble = 1'b0;
        drive(2'b10, 2'b00, 4'b1010, 32'h0BAD_F00D, 32'h1, 32'h2, 32'h300,
              13, 14, 15);
        for (int i = 0; i < 65540; i++) begin
            n = (2 + i > 65535) ? 65535 : 2 + i;
            exp_d = mk(2'b10, 2'b00, 4'b1010, 32'h0BAD_F00D, 32'h1, 32'h2,
                       32'h300, 13, 14, 15, 1'b1, 0, n, 1);
            step((i % 8192 == 0) || (i >= 65530), "long_cap", exp_d);
        end

        bubble = 1'b1;
        step(1, "sat_bubble", zs(65535, 2));

        bubble = 1'b0;
        step(1, "sat_stick",
             mk(2'b10, 2'b00, 4'b1010, 32'h0BAD_F00D, 32'h1, 32'h2,
                32'h300, 13, 14, 15, 1'b1, 0, 65535, 2));

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
